// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and bridge state type for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Address to one-hot APB select; each slave owns one 2**SLV_SEL_LSB byte window.
module apb_addr_decode #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SLV_SEL_LSB = 12
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  range_err
);

  // Whole upper address is the window number, so anything past the last slave errors.
  logic [ADDR_W-1:0] win;
  assign win = addr >> SLV_SEL_LSB;

  always_comb begin
    sel       = '0;
    range_err = (win >= ADDR_W'(NUM_SLAVES));
    if (!range_err) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (win == ADDR_W'(i)) sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb2apb_bridge_nslv.sv
// AHB-Lite slave to NUM_SLAVES APB peripherals with wait states, slave errors,
// decode errors and an ACCESS-phase timeout. All outputs are registered.
module ahb2apb_bridge_nslv
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SLV_SEL_LSB    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  iHCLK,
  input  logic                  iHRESET,
  input  logic                  iHSEL,
  input  logic [1:0]            iHTRANS,
  input  logic [2:0]            iHSIZE,
  input  logic                  iHWRITE,
  input  logic [ADDR_W-1:0]     iHADDR,
  input  logic [DATA_W-1:0]     iHWDATA,
  output logic                  oHREADY,
  output logic [1:0]            oHRESP,
  output logic [DATA_W-1:0]     oHRDATA,
  output logic [NUM_SLAVES-1:0] oPSEL,
  output logic                  oPENABLE,
  output logic                  oPWRITE,
  output logic [ADDR_W-1:0]     oPADDR,
  output logic [DATA_W-1:0]     oPWDATA,
  input  logic [DATA_W-1:0]     iPRDATA,
  input  logic                  iPREADY,
  input  logic                  iPSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t                state_q, state_d;
  logic                  hready_q, hready_d;
  logic [1:0]            hresp_q, hresp_d;
  logic [DATA_W-1:0]     hrdata_q, hrdata_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [NUM_SLAVES-1:0] sel_lat_q, sel_lat_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [DATA_W-1:0]     pwdata_q, pwdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  accept;
  logic                  timeout_hit;

  apb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .SLV_SEL_LSB (SLV_SEL_LSB)
  ) u_decode (
    .addr      (iHADDR),
    .sel       (dec_sel),
    .range_err (dec_err)
  );

  assign accept = iHSEL && ((iHTRANS == HTRANS_NONSEQ) || (iHTRANS == HTRANS_SEQ));

  // cnt_q holds the number of ACCESS cycles already spent waiting.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    state_d   = state_q;
    hready_d  = hready_q;
    hresp_d   = hresp_q;
    hrdata_d  = hrdata_q;
    psel_d    = psel_q;
    sel_lat_d = sel_lat_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        if (accept) begin
          paddr_d   = iHADDR;
          pwrite_d  = iHWRITE;
          sel_lat_d = dec_sel;
          hready_d  = 1'b0;
          if (dec_err || (iHSIZE != SIZE_WORD)) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (pwrite_q) pwdata_d = iHWDATA;
        psel_d    = sel_lat_q;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (iPREADY) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (iPSLVERR) begin
            state_d = ST_ERR1;
            hresp_d = HRESP_ERROR;
          end else begin
            state_d  = ST_IDLE;
            hready_d = 1'b1;
            if (!pwrite_q) hrdata_d = iPRDATA;
          end
        end else if (timeout_hit) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = ST_ERR1;
          hresp_d   = HRESP_ERROR;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      ST_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        psel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge iHCLK) begin
    if (iHRESET) begin
      state_q   <= ST_IDLE;
      hready_q  <= 1'b1;
      hresp_q   <= HRESP_OKAY;
      hrdata_q  <= '0;
      psel_q    <= '0;
      sel_lat_q <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      hrdata_q  <= hrdata_d;
      psel_q    <= psel_d;
      sel_lat_q <= sel_lat_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign oHREADY  = hready_q;
  assign oHRESP   = hresp_q;
  assign oHRDATA  = hrdata_q;
  assign oPSEL    = psel_q;
  assign oPENABLE = penable_q;
  assign oPWRITE  = pwrite_q;
  assign oPADDR   = paddr_q;
  assign oPWDATA  = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_nslv.sv
// Randomized self-checking bench: transfer-level model predicts wait counts, responses and APB signals.
module tb_ahb2apb_bridge_nslv;

  localparam int unsigned NS  = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LSB = 12;
  localparam int unsigned TO  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hready;
  logic [1:0]    hresp;
  logic [DW-1:0] hrdata;
  logic [NS-1:0] psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  always #5 clk = ~clk;

  ahb2apb_bridge_nslv #(
    .NUM_SLAVES     (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SLV_SEL_LSB    (LSB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .iHCLK    (clk),
    .iHRESET  (rst),
    .iHSEL    (hsel),
    .iHTRANS  (htrans),
    .iHSIZE   (hsize),
    .iHWRITE  (hwrite),
    .iHADDR   (haddr),
    .iHWDATA  (hwdata),
    .oHREADY  (hready),
    .oHRESP   (hresp),
    .oHRDATA  (hrdata),
    .oPSEL    (psel),
    .oPENABLE (penable),
    .oPWRITE  (pwrite),
    .oPADDR   (paddr),
    .oPWDATA  (pwdata),
    .iPRDATA  (prdata),
    .iPREADY  (pready),
    .iPSLVERR (pslverr)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One AHB transfer; waits = APB wait states the slave inserts before PREADY.
  task automatic xfer(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                      input logic [31:0] wdata, input int unsigned waits,
                      input logic slverr, input logic [31:0] rdata);
    logic [31:0]  win;
    logic         derr, exp_err, stable;
    logic [NS-1:0] exp_sel;
    logic [1:0]   last_resp;
    int unsigned  exp_low, exp_pc, low, pc, acc;

    win     = addr >> LSB;
    derr    = (win >= NS) || (size != 3'b010);
    exp_sel = '0;
    if (!derr) exp_sel[win[1:0]] = 1'b1;
    if (derr) begin
      exp_err = 1'b1; exp_low = 1;         exp_pc = 0;
    end else if (waits >= TO) begin
      exp_err = 1'b1; exp_low = TO + 3;    exp_pc = TO + 1;
    end else if (slverr) begin
      exp_err = 1'b1; exp_low = waits + 4; exp_pc = waits + 2;
    end else begin
      exp_err = 1'b0; exp_low = waits + 3; exp_pc = waits + 2;
    end

    hsel = 1'b1; htrans = 2'b10; haddr = addr; hsize = size; hwrite = wr;
    step();
    hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hsize = 3'($urandom);
    hwrite = 1'($urandom); hwdata = wdata;
    if (!derr && wr) m_wdata = wdata;

    low = 0; pc = 0; acc = 0; stable = 1'b1; last_resp = 2'b00;
    while (hready == 1'b0 && low < 40) begin
      low++;
      last_resp = hresp;
      if (psel != '0) begin
        pc++;
        if (psel !== exp_sel || paddr !== addr || pwrite !== wr || pwdata !== m_wdata)
          stable = 1'b0;
      end
      if (psel != '0 && penable) begin
        acc++;
        pready  = (acc > waits);
        pslverr = (acc > waits) ? slverr : 1'($urandom);
        prdata  = (acc > waits) ? rdata : $urandom;
      end else begin
        pready  = 1'b1;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
      step();
      hwdata = $urandom;
    end
    pready = 1'b1; pslverr = 1'b0;
    if (!exp_err && !wr) m_rdata = rdata;

    chk("wait_cycles", low, exp_low);
    chk("resp_last_wait", last_resp, exp_err ? 2'b01 : 2'b00);
    chk("resp_done", hresp, exp_err ? 2'b01 : 2'b00);
    chk("psel_cycles", pc, exp_pc);
    chk("apb_stable", stable, 1'b1);
    chk("psel_released", {penable, psel}, '0);
    chk("hrdata", hrdata, m_rdata);
    if (exp_err) begin
      step();
      chk("resp_okay_after_err", hresp, 2'b00);
      chk("hready_after_err", hready, 1'b1);
    end
  endtask

  task automatic idle_xfer(input logic s, input logic [1:0] t);
    hsel = s; htrans = t; haddr = 32'h0000_1000; hsize = 3'b010; hwrite = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'b00;
    chk("idle_hready", hready, 1'b1);
    chk("idle_resp", hresp, 2'b00);
    step();
    chk("idle_no_psel", psel, '0);
  endtask

  task automatic reset_mid_access();
    int unsigned n;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_2008; hsize = 3'b010; hwrite = 1'b1;
    step();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    pready = 1'b0;
    n = 0;
    while (!(psel != '0 && penable) && n < 10) begin
      n++;
      step();
    end
    chk("reached_access", {penable, psel}, {1'b1, 4'b0100});
    rst = 1'b1;
    step();
    rst = 1'b0;
    pready = 1'b1;
    m_rdata = '0; m_wdata = '0;
    chk("rst_psel", psel, '0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_hready", hready, 1'b1);
    chk("rst_hresp", hresp, 2'b00);
    chk("rst_paddr", paddr, '0);
    chk("rst_pwdata", pwdata, '0);
    chk("rst_hrdata", hrdata, '0);
    step();
    chk("rst_stays_idle", psel, '0);
  endtask

  initial begin
    int unsigned r, w;
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hsize = 3'b010; hwrite = 1'b0;
    haddr = '0; hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
    m_rdata = '0; m_wdata = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_hready", hready, 1'b1);
    chk("reset_hresp", hresp, 2'b00);
    chk("reset_hrdata", hrdata, '0);
    chk("reset_psel", psel, '0);
    chk("reset_penable", penable, 1'b0);
    chk("reset_pwrite", pwrite, 1'b0);
    chk("reset_paddr", paddr, '0);
    chk("reset_pwdata", pwdata, '0);

    xfer(32'h0000_1004, 3'b010, 1'b1, 32'h0000_00A5, 0, 1'b0, '0);
    xfer(32'h0000_3000, 3'b010, 1'b0, '0, 5, 1'b0, 32'hDEAD_BEEF);
    xfer(32'h0000_2010, 3'b010, 1'b1, 32'h5555_AAAA, 0, 1'b1, '0);
    xfer(32'h0000_5000, 3'b010, 1'b1, 32'h1111_1111, 0, 1'b0, '0);
    xfer(32'h0000_0000, 3'b000, 1'b0, '0, 0, 1'b0, 32'h2222_2222);
    xfer(32'h0000_1008, 3'b010, 1'b0, '0, 100, 1'b0, 32'h3333_3333);
    idle_xfer(1'b0, 2'b10);
    idle_xfer(1'b1, 2'b00);
    idle_xfer(1'b1, 2'b01);
    xfer(32'h0000_0040, 3'b010, 1'b1, 32'hCAFE_0000, 0, 1'b0, '0);
    xfer(32'h0000_3FFC, 3'b010, 1'b1, 32'hCAFE_0003, 0, 1'b0, '0);
    reset_mid_access();

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        w = $urandom_range(0, 2);
        if (w == 0) idle_xfer(1'b0, 2'b11);
        else        idle_xfer(1'b1, 2'(w - 1));
      end else begin
        xfer(($urandom_range(0, 5) << LSB) | ($urandom & 32'h0000_0FFC),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 1)) : 3'b010,
             1'($urandom), $urandom, $urandom_range(0, 8),
             ($urandom_range(0, 4) == 0), $urandom);
      end
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
